// File: rtl/cmplx_pkg.sv
// Shared widths and the round/saturate helper for the complex multiplier.
// Helper arithmetic runs at the widest legal accumulator so no sum can wrap.
package cmplx_pkg;

  localparam int DIN_W_DEF  = 16;
  localparam int DOUT_W_DEF = 16;
  localparam int SHIFT_DEF  = 15;
  localparam int TAG_W_DEF  = 8;

  // 2*32+2: widest sum the multiplier can produce
  localparam int ACC_W = 66;

  typedef struct packed {
    logic [ACC_W-1:0] val;
    logic             ovf;
  } rs_t;

  function automatic rs_t round_sat(
    input logic signed [ACC_W-1:0] x,
    input int                      shift,
    input int                      dout_w
  );
    logic signed [ACC_W:0] one;
    logic signed [ACC_W:0] r;
    logic signed [ACC_W:0] hi;
    logic signed [ACC_W:0] lo;
    rs_t res;
    one    = '0;
    one[0] = 1'b1;
    r = {x[ACC_W-1], x};
    if (shift > 0)
      r = r + (one <<< (shift - 1));
    r  = r >>> shift;
    hi = (one <<< (dout_w - 1)) - one;
    lo = -(one <<< (dout_w - 1));
    res.val = r[ACC_W-1:0];
    res.ovf = 1'b0;
    if (r > hi) begin
      res.val = hi[ACC_W-1:0];
      res.ovf = 1'b1;
    end else if (r < lo) begin
      res.val = lo[ACC_W-1:0];
      res.ovf = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/cmplx_round_sat.sv
// Round-half-up, arithmetic shift and clamp of one full-precision component.
// Purely combinational; one instance per real/imag lane.
module cmplx_round_sat
  import cmplx_pkg::*;
#(
  parameter int IN_W   = 34,
  parameter int DOUT_W = 16,
  parameter int SHIFT  = 15
) (
  input  logic signed [IN_W-1:0]   din,
  output logic signed [DOUT_W-1:0] dout,
  output logic                     ovf
);

  logic signed [ACC_W-1:0] ext;
  rs_t                     r;
  logic                    unused_hi;

  assign ext  = ACC_W'(din);
  assign r    = round_sat(ext, SHIFT, DOUT_W);
  assign dout = r.val[DOUT_W-1:0];
  assign ovf  = r.ovf;

  // clamped value always fits in DOUT_W; upper bits are sign copies
  assign unused_hi = ^r.val[ACC_W-1:DOUT_W];

endmodule

// File: rtl/complex_mult_stream.sv
// Streaming complex multiply h*y or h*conj(y), three register stages,
// single global advance enable driven by output backpressure.
module complex_mult_stream
  import cmplx_pkg::*;
#(
  parameter int DIN_W  = DIN_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF,
  parameter int SHIFT  = SHIFT_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic signed [DIN_W-1:0]  i_real_h,
  input  logic signed [DIN_W-1:0]  i_imag_h,
  input  logic signed [DIN_W-1:0]  i_real_y,
  input  logic signed [DIN_W-1:0]  i_imag_y,
  input  logic                     i_conj,
  input  logic [TAG_W-1:0]         i_tag,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic signed [DOUT_W-1:0] o_real,
  output logic signed [DOUT_W-1:0] o_imag,
  output logic [TAG_W-1:0]         o_tag,
  output logic                     o_ovf
);

  localparam int PROD_W = 2 * DIN_W;
  localparam int SUM_W  = 2 * DIN_W + 2;

  logic                     en;

  logic                     s1_v;
  logic signed [DIN_W-1:0]  s1_a, s1_b, s1_c, s1_d;
  logic                     s1_conj;
  logic [TAG_W-1:0]         s1_tag;

  logic                     s2_v;
  logic signed [PROD_W-1:0] s2_ac, s2_bd, s2_ad, s2_bc;
  logic                     s2_conj;
  logic [TAG_W-1:0]         s2_tag;

  logic signed [SUM_W-1:0]  sum_re, sum_im;
  logic signed [DOUT_W-1:0] rs_re, rs_im;
  logic                     ovf_re, ovf_im;

  assign en      = ~o_valid | i_ready;
  assign o_ready = en;

  always_comb begin
    if (s2_conj) begin
      sum_re = SUM_W'(s2_ac) + SUM_W'(s2_bd);
      sum_im = SUM_W'(s2_bc) - SUM_W'(s2_ad);
    end else begin
      sum_re = SUM_W'(s2_ac) - SUM_W'(s2_bd);
      sum_im = SUM_W'(s2_ad) + SUM_W'(s2_bc);
    end
  end

  cmplx_round_sat #(
    .IN_W  (SUM_W),
    .DOUT_W(DOUT_W),
    .SHIFT (SHIFT)
  ) u_rs_re (
    .din (sum_re),
    .dout(rs_re),
    .ovf (ovf_re)
  );

  cmplx_round_sat #(
    .IN_W  (SUM_W),
    .DOUT_W(DOUT_W),
    .SHIFT (SHIFT)
  ) u_rs_im (
    .din (sum_im),
    .dout(rs_im),
    .ovf (ovf_im)
  );

  // data regs need no reset: only the valid bits qualify them
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      o_valid <= 1'b0;
      o_real  <= '0;
      o_imag  <= '0;
      o_tag   <= '0;
      o_ovf   <= 1'b0;
    end else if (en) begin
      s1_v    <= i_valid;
      s1_a    <= i_real_h;
      s1_b    <= i_imag_h;
      s1_c    <= i_real_y;
      s1_d    <= i_imag_y;
      s1_conj <= i_conj;
      s1_tag  <= i_tag;
      s2_v    <= s1_v;
      s2_ac   <= PROD_W'(s1_a) * PROD_W'(s1_c);
      s2_bd   <= PROD_W'(s1_b) * PROD_W'(s1_d);
      s2_ad   <= PROD_W'(s1_a) * PROD_W'(s1_d);
      s2_bc   <= PROD_W'(s1_b) * PROD_W'(s1_c);
      s2_conj <= s1_conj;
      s2_tag  <= s1_tag;
      o_valid <= s2_v;
      o_real  <= rs_re;
      o_imag  <= rs_im;
      o_tag   <= s2_tag;
      o_ovf   <= ovf_re | ovf_im;
    end
  end

endmodule

// File: tb/tb_complex_mult_stream.sv
// Bench for complex_mult_stream: default-width instance plus a
// full-precision instance (SHIFT=0, DOUT_W=33) sharing one input stream.
module tb_complex_mult_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, valid, conj, ready;
  logic signed [15:0] rh, ih, ry, iy;
  logic [7:0]        tag;

  logic              rdy_a, va, oa;
  logic signed [15:0] ra, ia;
  logic [7:0]        ta;
  logic              rdy_b, vb, ob;
  logic signed [32:0] rb, ib;
  logic [7:0]        tb;

  complex_mult_stream u_a (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy_a),
    .i_real_h(rh), .i_imag_h(ih), .i_real_y(ry), .i_imag_y(iy),
    .i_conj(conj), .i_tag(tag), .o_valid(va), .i_ready(ready),
    .o_real(ra), .o_imag(ia), .o_tag(ta), .o_ovf(oa)
  );

  complex_mult_stream #(
    .DIN_W(16), .DOUT_W(33), .SHIFT(0), .TAG_W(8)
  ) u_b (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(rdy_b),
    .i_real_h(rh), .i_imag_h(ih), .i_real_y(ry), .i_imag_y(iy),
    .i_conj(conj), .i_tag(tag), .o_valid(vb), .i_ready(ready),
    .o_real(rb), .o_imag(ib), .o_tag(tb), .o_ovf(ob)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void rnd(input longint x, input int sh, input int dw,
                              output longint y, output bit ov);
    longint mx, mn;
    if (sh > 0) x = x + (longint'(1) <<< (sh - 1));
    x  = x >>> sh;
    mx = (longint'(1) <<< (dw - 1)) - 1;
    mn = -mx - 1;
    ov = 1'b0;
    y  = x;
    if (x > mx) begin y = mx; ov = 1'b1; end
    if (x < mn) begin y = mn; ov = 1'b1; end
  endfunction

  function automatic void model(input logic signed [15:0] a, b, c, d,
                                input bit cj, input int sh, input int dw,
                                output longint re, output longint im,
                                output bit ov);
    longint r, i;
    bit o1, o2;
    if (cj) begin
      r = longint'(a) * longint'(c) + longint'(b) * longint'(d);
      i = longint'(b) * longint'(c) - longint'(a) * longint'(d);
    end else begin
      r = longint'(a) * longint'(c) - longint'(b) * longint'(d);
      i = longint'(a) * longint'(d) + longint'(b) * longint'(c);
    end
    rnd(r, sh, dw, re, o1);
    rnd(i, sh, dw, im, o2);
    ov = o1 | o2;
  endfunction

  typedef struct {
    longint   ra, ia, rb, ib;
    bit       oa, ob;
    logic [7:0] tg;
  } exp_t;

  exp_t q[$];

  bit stall = 1'b0;
  logic signed [15:0] p_ra, p_ia;
  logic signed [32:0] p_rb, p_ib;
  logic [7:0] p_ta;
  logic p_oa;

  // scoreboard: push on acceptance, pop on output handshake
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stall = 1'b0;
    end else begin
      chk("ready_rule", rdy_a, !va || ready);
      chk("ready_b", rdy_b, rdy_a);
      if (stall) begin
        chk("stall_valid", va, 1);
        chk("stall_real_a", ra, p_ra);
        chk("stall_imag_a", ia, p_ia);
        chk("stall_tag", ta, p_ta);
        chk("stall_ovf", oa, p_oa);
        chk("stall_real_b", rb, p_rb);
        chk("stall_imag_b", ib, p_ib);
      end
      if (va || vb) begin
        if (q.size() == 0) begin
          chk("spurious_valid", va | vb, 0);
        end else begin
          chk("valid_b", vb, va);
          chk("real_a", ra, q[0].ra);
          chk("imag_a", ia, q[0].ia);
          chk("ovf_a", oa, q[0].oa);
          chk("tag_a", ta, q[0].tg);
          chk("real_b", rb, q[0].rb);
          chk("imag_b", ib, q[0].ib);
          chk("ovf_b", ob, q[0].ob);
          chk("tag_b", tb, q[0].tg);
          if (ready) void'(q.pop_front());
        end
      end
      stall = va && !ready;
      p_ra = ra; p_ia = ia; p_rb = rb; p_ib = ib; p_ta = ta; p_oa = oa;
      if (valid && rdy_a) begin
        exp_t e;
        model(rh, ih, ry, iy, conj, 15, 16, e.ra, e.ia, e.oa);
        model(rh, ih, ry, iy, conj, 0, 33, e.rb, e.ib, e.ob);
        e.tg = tag;
        q.push_back(e);
      end
    end
  end

  task automatic one_beat(input logic signed [15:0] a, b, c, d,
                          input bit cj, input logic [7:0] tg,
                          output int lat);
    @(posedge clk); #1;
    ready = 1'b1;
    valid = 1'b1;
    rh = a; ih = b; ry = c; iy = d; conj = cj; tag = tg;
    lat = 0;
    do begin
      @(posedge clk); #1;
      valid = 1'b0;
      lat++;
      @(negedge clk);
    end while (!va && lat < 10);
  endtask

  int lat;
  int sent;
  int cyc;

  initial begin
    rst = 1'b1; valid = 1'b0; ready = 1'b1; conj = 1'b0;
    rh = '0; ih = '0; ry = '0; iy = '0; tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid_a", va, 0);
    chk("rst_valid_b", vb, 0);
    chk("rst_real", ra, 0);
    chk("rst_imag", ia, 0);
    chk("rst_tag", ta, 0);
    chk("rst_ovf", oa, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", rdy_a, 1);

    // full precision, plain product
    one_beat(3, 4, 1, 2, 1'b0, 8'h5A, lat);
    chk("lat_034", lat, 3);
    chk("lit_real_b", rb, -5);
    chk("lit_imag_b", ib, 10);
    chk("lit_tag_b", tb, 8'h5A);
    chk("lit_ovf_b", ob, 0);

    // full precision, conjugate
    one_beat(3, 4, 1, 2, 1'b1, 8'h5B, lat);
    chk("lat_035", lat, 3);
    chk("lit_cj_real_b", rb, 11);
    chk("lit_cj_imag_b", ib, -2);

    // positive saturation at default widths
    one_beat(-32768, 0, -32768, 0, 1'b0, 8'h01, lat);
    chk("lit_sat_real_a", ra, 32767);
    chk("lit_sat_ovf_a", oa, 1);
    chk("lit_nosat_real_b", rb, 1073741824);

    // 1.5 rounds up to 2, -1.5 rounds up to -1
    one_beat(3, 0, 16384, 0, 1'b0, 8'h02, lat);
    chk("lit_rnd_pos", ra, 2);
    chk("lit_rnd_ovf", oa, 0);
    one_beat(-3, 0, 16384, 0, 1'b0, 8'h03, lat);
    chk("lit_rnd_neg", ra, -1);

    // negative saturation on real, imag stays in range
    one_beat(-32768, 32767, 32767, 32767, 1'b0, 8'h04, lat);
    chk("lit_nsat_real", ra, -32768);
    chk("lit_nsat_imag", ia, -1);
    chk("lit_nsat_ovf", oa, 1);

    // random stream with random backpressure and input gaps
    sent = 0;
    cyc  = 0;
    while (sent < 20 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      ready = ($urandom_range(0, 2) != 0);
      valid = ($urandom_range(0, 3) != 0);
      rh   = 16'($urandom);
      ih   = 16'($urandom);
      ry   = 16'($urandom);
      iy   = 16'($urandom);
      conj = 1'($urandom);
      tag  = 8'(sent + 16);
      @(negedge clk);
      if (valid && rdy_a) sent++;
    end
    chk("stream_sent", sent, 20);
    @(posedge clk); #1;
    valid = 1'b0;
    ready = 1'b1;
    cyc = 0;
    while ((q.size() != 0 || va) && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    chk("drain_empty", q.size(), 0);

    // reset with three beats in flight
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      valid = 1'b1;
      rh = 16'(100 + k); ih = 7; ry = 9; iy = -5;
      conj = 1'b0; tag = 8'(k + 200);
    end
    @(posedge clk); #1;
    valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("flush_valid_a", va, 0);
    chk("flush_valid_b", vb, 0);
    chk("flush_ready", rdy_a, 1);
    repeat (6) @(negedge clk);
    chk("flush_queue", q.size(), 0);

    // stream resumes cleanly after the flush
    one_beat(3, 4, 1, 2, 1'b0, 8'h77, lat);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_real_b", rb, -5);
    chk("post_rst_tag", tb, 8'h77);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
